// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: generic inter-stage pipeline register with a 2-entry skid
// buffer. out_valid/out_data come straight from the main entry register and
// in_ready is a register, so no combinational ready path crosses stages.
// Optional feature macro: PIPE_STAGE_PERF_EN (saturating perf counters and
// the perf_clr / perf_* ports). With it undefined those ports do not exist.
module pipe_stage_buf #(
  parameter int                 DATA_W    = 64,
  parameter logic [DATA_W-1:0]  RESET_VAL = {DATA_W{1'b0}},
  parameter int                 CNT_W     = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
  ,
  input  logic              perf_clr,
  output logic [CNT_W-1:0]  perf_xfer,
  output logic [CNT_W-1:0]  perf_stall,
  output logic [CNT_W-1:0]  perf_bubble
`endif
);

  // Elaboration-time sanity on the widths.
  if (DATA_W < 1) begin : g_bad_data_w
    $error("pipe_stage_buf: DATA_W must be at least 1");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("pipe_stage_buf: CNT_W must be at least 1");
  end

  // Storage: main entry feeds the output, skid entry catches the one extra
  // beat accepted while downstream stalls.
  logic              main_valid_r;
  logic [DATA_W-1:0] main_data_r;
  logic              skid_valid_r;
  logic [DATA_W-1:0] skid_data_r;
  logic              in_ready_r;

  logic              main_valid_s;
  logic [DATA_W-1:0] main_data_s;
  logic              skid_valid_s;
  logic [DATA_W-1:0] skid_data_s;
  logic              in_ready_s;

  logic              in_fire_s;
  logic              out_fire_s;

  assign in_fire_s  = in_valid & in_ready_r;
  assign out_fire_s = main_valid_r & out_ready;

  assign in_ready  = in_ready_r;
  assign out_valid = main_valid_r;
  assign out_data  = main_data_r;

  // Next-state computation for the EMPTY / ONE / TWO occupancy, flush first.
  always_comb begin
    main_valid_s = main_valid_r;
    main_data_s  = main_data_r;
    skid_valid_s = skid_valid_r;
    skid_data_s  = skid_data_r;
    if (flush) begin
      // Flush wins over a same-cycle in_fire; any out_fire is already taken.
      main_valid_s = 1'b0;
      main_data_s  = RESET_VAL;
      skid_valid_s = 1'b0;
      skid_data_s  = RESET_VAL;
    end else begin
      case ({main_valid_r, skid_valid_r})
        2'b00: begin
          if (in_fire_s) begin
            main_valid_s = 1'b1;
            main_data_s  = in_data;
          end else begin
            main_valid_s = 1'b0;
          end
        end
        2'b10: begin
          if (in_fire_s && out_fire_s) begin
            main_data_s = in_data;
          end else if (in_fire_s) begin
            skid_valid_s = 1'b1;
            skid_data_s  = in_data;
          end else if (out_fire_s) begin
            // Drained: main_data keeps its last value.
            main_valid_s = 1'b0;
          end else begin
            main_valid_s = 1'b1;
          end
        end
        2'b11: begin
          // in_ready is low here, so only the output side can move.
          if (out_fire_s) begin
            main_data_s  = skid_data_r;
            skid_valid_s = 1'b0;
          end else begin
            skid_valid_s = 1'b1;
          end
        end
        default: begin
          // Skid without main is unreachable; recover to EMPTY.
          main_valid_s = 1'b0;
          main_data_s  = RESET_VAL;
          skid_valid_s = 1'b0;
          skid_data_s  = RESET_VAL;
        end
      endcase
    end
    in_ready_s = ~skid_valid_s;
  end

  // State registers with asynchronous reset to the NOP payload.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_valid_r <= 1'b0;
      main_data_r  <= RESET_VAL;
      skid_valid_r <= 1'b0;
      skid_data_r  <= RESET_VAL;
      in_ready_r   <= 1'b1;
    end else begin
      main_valid_r <= main_valid_s;
      main_data_r  <= main_data_s;
      skid_valid_r <= skid_valid_s;
      skid_data_r  <= skid_data_s;
      in_ready_r   <= in_ready_s;
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_W-1:0] perf_xfer_r;
  logic [CNT_W-1:0] perf_stall_r;
  logic [CNT_W-1:0] perf_bubble_r;

  assign perf_xfer   = perf_xfer_r;
  assign perf_stall  = perf_stall_r;
  assign perf_bubble = perf_bubble_r;

  // Saturating increment: sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      return v;
    end else begin
      return v + CNT_W'(1);
    end
  endfunction

  // Performance counters; perf_clr beats a same-cycle increment, flush ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_xfer_r   <= {CNT_W{1'b0}};
      perf_stall_r  <= {CNT_W{1'b0}};
      perf_bubble_r <= {CNT_W{1'b0}};
    end else if (perf_clr) begin
      perf_xfer_r   <= {CNT_W{1'b0}};
      perf_stall_r  <= {CNT_W{1'b0}};
      perf_bubble_r <= {CNT_W{1'b0}};
    end else begin
      perf_xfer_r   <= out_fire_s ? sat_inc(perf_xfer_r) : perf_xfer_r;
      perf_stall_r  <= (main_valid_r & ~out_ready) ? sat_inc(perf_stall_r) : perf_stall_r;
      perf_bubble_r <= (~main_valid_r) ? sat_inc(perf_bubble_r) : perf_bubble_r;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Scoreboard bench for pipe_stage_buf. The driver issues stimulus shortly
// after each rising edge and pushes accepted payloads into exp_q (a plain
// FIFO of capacity 2 that models the buffer); the monitor samples on the
// falling edge and pops/compares whenever the DUT presents an output transfer.
module tb_pipe_stage_buf;
  localparam int DW = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          perf_clr;
`ifdef PIPE_STAGE_PERF_EN
  logic [CW-1:0] perf_xfer;
  logic [CW-1:0] perf_stall;
  logic [CW-1:0] perf_bubble;
`endif

  pipe_stage_buf #(.DATA_W(DW), .RESET_VAL({DW{1'b0}}), .CNT_W(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .perf_clr    (perf_clr),
    .perf_xfer   (perf_xfer),
    .perf_stall  (perf_stall),
    .perf_bubble (perf_bubble)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state.
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] hold_d = '0;
  logic          pend_push = 1'b0;
  logic          pend_flush = 1'b0;
  logic [DW-1:0] pend_data = '0;
  logic [CW-1:0] m_xfer = '0, m_stall = '0, m_bubble = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [CW-1:0] sat(input logic [CW-1:0] v);
    return (v == {CW{1'b1}}) ? v : v + 1'b1;
  endfunction

  // One clock of stimulus: commit last cycle's predicted effect, then drive.
  task automatic cycle(input logic iv, input logic [DW-1:0] d, input logic ordy,
                       input logic fl, input logic pc);
    @(posedge clk);
    #1;
    if (pend_flush) begin
      exp_q.delete();
      hold_d = '0;
    end else if (pend_push) begin
      exp_q.push_back(pend_data);
    end
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    perf_clr  = pc;
    pend_flush = fl;
    pend_push  = iv && (exp_q.size() < 2) && !fl;
    pend_data  = d;
  endtask

  // Reset asserted between clock edges; outputs must react immediately.
  task automatic reset_mid();
    @(posedge clk);
    #2;
    reset    = 1'b1;
    in_valid = 1'b0;
    flush    = 1'b0;
    perf_clr = 1'b0;
    exp_q.delete();
    hold_d     = '0;
    pend_push  = 1'b0;
    pend_flush = 1'b0;
    m_xfer = '0; m_stall = '0; m_bubble = '0;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_data", out_data, '0);
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Monitor: compare visible state against the model, pop on output transfers.
  initial begin
    forever begin
      int sz;
      logic [DW-1:0] exp_d;
      @(negedge clk);
      sz = exp_q.size();
      exp_d = (sz > 0) ? exp_q[0] : hold_d;
      chk("out_valid", out_valid, sz > 0);
      chk("in_ready", in_ready, sz < 2);
      chk("out_data", out_data, exp_d);
`ifdef PIPE_STAGE_PERF_EN
      chk("perf_xfer", perf_xfer, m_xfer);
      chk("perf_stall", perf_stall, m_stall);
      chk("perf_bubble", perf_bubble, m_bubble);
      if (!reset) begin
        if (perf_clr) begin
          m_xfer = '0; m_stall = '0; m_bubble = '0;
        end else begin
          if (sz > 0 && out_ready)  m_xfer   = sat(m_xfer);
          if (sz > 0 && !out_ready) m_stall  = sat(m_stall);
          if (sz == 0)              m_bubble = sat(m_bubble);
        end
      end
`endif
      if (!reset && out_valid === 1'b1 && out_ready === 1'b1) begin
        if (sz == 0) begin
          chk("xfer_unexpected", 1'b1, 1'b0);
        end else begin
          chk("xfer_order", out_data, exp_q[0]);
          hold_d = exp_q.pop_front();
        end
      end
    end
  end

  initial begin
    logic accepted;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0;
    out_ready = 1'b0; perf_clr = 1'b0;
    #1;
    chk("init_out_valid", out_valid, 1'b0);
    chk("init_in_ready", in_ready, 1'b1);
    chk("init_out_data", out_data, '0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset then idle, asserted mid-cycle.
    reset_mid();
    repeat (2) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Streaming 1..8 at full rate.
    for (int i = 1; i <= 8; i++) cycle(1'b1, DW'(i), 1'b1, 1'b0, 1'b0);
    repeat (3) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Backpressure into the skid entry; 0xC waits upstream.
    cycle(1'b1, 32'hA, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'hB, 1'b0, 1'b0, 1'b0);
    repeat (3) cycle(1'b1, 32'hC, 1'b0, 1'b0, 1'b0);
    accepted = 1'b0;
    for (int k = 0; k < 10 && !accepted; k++) begin
      cycle(1'b1, 32'hC, 1'b1, 1'b0, 1'b0);
      accepted = pend_push;
    end
    chk("bp_accept_bound", accepted, 1'b1);
    repeat (4) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Flush in state TWO beats a simultaneous input 0xD.
    cycle(1'b1, 32'hA, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'hB, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'hD, 1'b0, 1'b1, 1'b0);
    repeat (3) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Reset in state ONE holding 0x5, then 0x6 with latency 1.
    cycle(1'b1, 32'h5, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
    reset_mid();
    cycle(1'b1, 32'h6, 1'b1, 1'b0, 1'b0);
    repeat (2) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);

`ifdef PIPE_STAGE_PERF_EN
    // Stall saturation, clear, then three transfers.
    cycle(1'b1, 32'h7, 1'b0, 1'b0, 1'b0);
    repeat (21) cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 32'h1, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 32'h2, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 32'h3, 1'b1, 1'b0, 1'b0);
    repeat (2) cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
`endif

    // Randomised traffic with occasional flush, clear and one mid-run reset.
    for (int i = 0; i < 600; i++) begin
      if (i == 300) reset_mid();
      cycle($urandom_range(0, 3) != 0, DW'($urandom), $urandom_range(0, 3) != 0,
            $urandom_range(0, 19) == 0, $urandom_range(0, 29) == 0);
    end
    repeat (4) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
- Parametrised successor to the fixed-width IF/ID latch: a generic inter-stage pipeline register carrying a DATA_W-bit payload.
- Full valid/ready handshake in both directions, plus a flush input.
- A 2-entry skid buffer gives full throughput with a registered in_ready, so no combinational ready path crosses stages.
- Drops between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB), with flush driven by hazard/branch logic.

Parameters:
- DATA_W, 64, payload width in bits (e.g. instruction 32 + PC+4 32).
- RESET_VAL, 0, payload value loaded on reset and on flush (all-zero = NOP encoding).
- CNT_W, 32, performance counter width (used only with PIPE_STAGE_PERF_EN).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  discard all held entries at next edge.
- in_valid  in  1  upstream payload valid.
- in_ready  out  1  buffer can accept; registered.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  payload at out_data valid.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_W  payload to next stage; registered.
- perf_clr  in  1  synchronous counter clear (PIPE_STAGE_PERF_EN only).
- perf_xfer  out  CNT_W  output transfers (PIPE_STAGE_PERF_EN only).
- perf_stall  out  CNT_W  cycles with out_valid=1 and out_ready=0 (PIPE_STAGE_PERF_EN only).
- perf_bubble  out  CNT_W  cycles with out_valid=0 (PIPE_STAGE_PERF_EN only).

Behaviour:
- Clock and reset: single clock clk; reset is asynchronous and active-high.
- Storage:
  - main entry: main_valid, main_data; drives out_valid and out_data directly.
  - skid entry: skid_valid, skid_data.
- Handshake definitions:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - in_ready = !skid_valid; registered, never a function of out_ready in the same cycle.
- Reset values: main_valid=0, skid_valid=0, out_valid=0, in_ready=1, main_data=skid_data=RESET_VAL, so out_data=RESET_VAL.
- Latency: 1 cycle from in_fire to out_valid when empty. Throughput 1/cycle while out_ready=1.
- States (encoded by main_valid/skid_valid): EMPTY (0/0), ONE (1/0), TWO (1/1). Transitions when flush=0:
  - EMPTY: in_fire -> ONE, main<=in_data. Otherwise stay.
  - ONE, in_fire & out_fire -> ONE, main<=in_data.
  - ONE, in_fire & !out_fire -> TWO, skid<=in_data.
  - ONE, !in_fire & out_fire -> EMPTY; main_data holds last value.
  - ONE, neither -> stay; main_data stable.
  - TWO: in_ready=0, so no in_fire. out_fire -> ONE, main<=skid_data. Otherwise hold.
- Ordering: strict FIFO, no duplication, no loss except by flush.
- Flush:
  - Any state -> EMPTY at next edge; main_data and skid_data <= RESET_VAL.
  - Flush beats a simultaneous in_fire: that input is dropped.
  - A simultaneous out_fire still counts as taken by downstream.
  - in_ready=1 the cycle after flush.
- Reset mid-operation: immediate return to reset values regardless of clk; in-flight entries lost.
- Stability: while out_valid=1 and out_ready=0, out_data and out_valid must not change (flush excepted).

Optional Feature:
- Macro: PIPE_STAGE_PERF_EN.
- With macro defined:
  - perf_* counters present, each CNT_W bits, saturating at all-ones, no wrap.
  - Reset and perf_clr zero them; perf_clr beats a same-cycle increment.
  - Flush does not clear them.
- Without macro: perf_clr and perf_* ports and all counter logic absent; behaviour otherwise identical.

Test Plan:
- Reset then idle: assert reset mid-cycle with no clk edge -> out_valid=0, in_ready=1 and out_data=0 immediately; hold 5 cycles, all unchanged.
- Streaming: in_valid=1 with data 0x1..0x8 on consecutive cycles, out_ready=1 -> out_data 0x1..0x8 on consecutive cycles, each one cycle after input, in_ready stays 1.
- Backpressure/skid: push 0xA, 0xB, 0xC with out_ready=0 -> after 0xB in_ready=0 and 0xC is held upstream; raise out_ready -> outputs 0xA, 0xB, 0xC in order, no loss or duplicate.
- Flush priority: state TWO (0xA, 0xB); flush=1 with in_valid=1, data 0xD -> next cycle out_valid=0, out_data=RESET_VAL, in_ready=1, 0xD never appears.
- Reset mid-stream: state ONE holding 0x5, assert reset between edges -> out_valid=0 and out_data=0 immediately; first post-reset input 0x6 emerges with latency 1.
- PIPE_STAGE_PERF_EN, CNT_W=4: 20 stalled cycles -> perf_stall saturates at 15; perf_clr -> 0 next cycle; 3 transfers -> perf_xfer=3.
